// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready Y86-64 OPq ALU (ADD/SUB/AND/XOR) with result flags and CC register
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : input handshake; a, b, fun, set_cc captured on transfer
//   out_valid/out_ready     : output handshake; X, out_zf/sf/of, out_err describe the presented result
//   cc                      : architectural {ZF,SF,OF}, updated when a legal set_cc op transfers out
module alu_pipe #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fun,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_err,
  output logic [2:0]       cc
);
  logic             r_s1_valid, r_s1_set_cc, r_s2_valid, r_s2_set_cc;
  logic [WIDTH-1:0] r_a, r_b, r_x;
  logic [3:0]       r_fun;
  logic             r_zf, r_sf, r_of, r_err;
  logic [2:0]       r_cc;
  logic             w_s2_load, w_ill, w_zf, w_of, w_cc_upd;
  logic [WIDTH-1:0] w_sum, w_dif, w_x;
  // stage 2 takes a new entry when empty or when its current result leaves this cycle
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_sum     = r_b + r_a;
  assign w_dif     = r_b - r_a;
  assign w_ill     = |r_fun[3:2];
  always_comb begin
    w_x  = r_fun == 4'd0 ? w_sum :
           r_fun == 4'd1 ? w_dif :
           r_fun == 4'd2 ? (r_b & r_a) :
           r_fun == 4'd3 ? (r_b ^ r_a) : '0;
    w_of = r_fun == 4'd0 ? (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]) :
           r_fun == 4'd1 ? (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_b[WIDTH-1]) : 1'b0;
    w_zf = !w_ill && (w_x == '0);
  end
  // only a legal op with set_cc writes cc, and only on the edge its result leaves
  assign w_cc_upd = r_s2_valid && out_ready && r_s2_set_cc && !r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_set_cc <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_fun       <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_set_cc <= 1'b0;
      r_x         <= '0;
      r_zf        <= 1'b0;
      r_sf        <= 1'b0;
      r_of        <= 1'b0;
      r_err       <= 1'b0;
      r_cc        <= CC_RESET;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_a         <= a;
          r_b         <= b;
          r_fun       <= fun;
          r_s1_set_cc <= set_cc;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_x         <= w_x;
          r_zf        <= w_zf;
          r_sf        <= w_x[WIDTH-1];
          r_of        <= w_of;
          r_err       <= w_ill;
          r_s2_set_cc <= r_s1_set_cc;
        end
      end
      if (w_cc_upd) r_cc <= {r_zf, r_sf, r_of};
    end
  end
  assign out_valid = r_s2_valid;
  assign X         = r_x;
  assign out_zf    = r_zf;
  assign out_sf    = r_sf;
  assign out_of    = r_of;
  assign out_err   = r_err;
  assign cc        = r_cc;
endmodule
